// File: rtl/count_pkg.sv
// Shared types and default sizing for the multi-channel count adder.
package count_pkg;

  localparam int unsigned COUNT_CH = 4;
  localparam int unsigned COUNT_CW = 15;
  localparam int unsigned COUNT_IW = 1;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } count_state_e;

endpackage

// File: rtl/count_lane.sv
// One channel: CW-bit accumulator with reload and sticky overflow.
// Define COUNT_SAT_EN to clamp at the maximum instead of wrapping.
module count_lane
  import count_pkg::*;
#(
  parameter int unsigned CW = COUNT_CW,
  parameter int unsigned IW = COUNT_IW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          reload,
  input  logic [IW-1:0] inc,
  output logic [CW-1:0] count,
  output logic          ovf
);

  localparam int unsigned SW = CW + 1;

  logic [SW-1:0] sum_c;

  // One extra bit catches the carry-out of the add.
  assign sum_c = SW'(count) + SW'(inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (reload) begin
      count <= CW'(inc);
      ovf   <= 1'b0;
    end else if (!hold) begin
`ifdef COUNT_SAT_EN
      if (sum_c[CW]) begin
        count <= {CW{1'b1}};
        ovf   <= 1'b1;
      end else begin
        count <= sum_c[CW-1:0];
      end
`else
      count <= sum_c[CW-1:0];
      if (sum_c[CW]) begin
        ovf <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: rtl/multi_count_adder.sv
// Multi-channel count adder: shared RUN/HOLD FSM, per-channel lanes and a
// snapshot register with valid/ready handshake. Honours COUNT_SAT_EN in the lanes.
module multi_count_adder
  import count_pkg::*;
#(
  parameter int unsigned CH = COUNT_CH,
  parameter int unsigned CW = COUNT_CW,
  parameter int unsigned IW = COUNT_IW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH*IW-1:0] in,
  input  logic             busy,
  output logic [CH*CW-1:0] count,
  output logic [CH-1:0]    ovf,
  output logic [CH*CW-1:0] snap_data,
  output logic             snap_valid,
  input  logic             snap_ready,
  output logic             snap_drop
);

  count_state_e state, state_nxt;
  logic         hold_c;
  logic         reload_c;
  logic         capture_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // A busy rise captures and holds; the busy fall reloads from the increment.
  always_comb begin
    state_nxt = state;
    hold_c    = 1'b0;
    reload_c  = 1'b0;
    capture_c = 1'b0;
    case (state)
      RUN: begin
        if (busy) begin
          hold_c    = 1'b1;
          capture_c = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (busy) begin
          hold_c = 1'b1;
        end else begin
          reload_c  = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  for (genvar k = 0; k < CH; k++) begin : g_lane
    count_lane #(
      .CW (CW),
      .IW (IW)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .hold   (hold_c),
      .reload (reload_c),
      .inc    (in[k*IW +: IW]),
      .count  (count[k*CW +: CW]),
      .ovf    (ovf[k])
    );
  end

  // A capture wins over a same-edge read; an unread snapshot being replaced flags a drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_data  <= '0;
      snap_valid <= 1'b0;
      snap_drop  <= 1'b0;
    end else begin
      snap_drop <= capture_c && snap_valid && !snap_ready;
      if (capture_c) begin
        snap_data  <= count;
        snap_valid <= 1'b1;
      end else if (snap_valid && snap_ready) begin
        snap_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multi_count_adder.sv
// Directed bench for multi_count_adder at CH=4, CW=4, IW=1; follows COUNT_SAT_EN.
module tb_multi_count_adder;

  logic        clk;
  logic        rst;
  logic [3:0]  in;
  logic        busy;
  logic [15:0] count;
  logic [3:0]  ovf;
  logic [15:0] snap_data;
  logic        snap_valid;
  logic        snap_ready;
  logic        snap_drop;

  int n_tests = 0;
  int n_fail  = 0;

  multi_count_adder #(
    .CH (4),
    .CW (4),
    .IW (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .busy       (busy),
    .count      (count),
    .ovf        (ovf),
    .snap_data  (snap_data),
    .snap_valid (snap_valid),
    .snap_ready (snap_ready),
    .snap_drop  (snap_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef COUNT_SAT_EN
  localparam logic [15:0] EXP_C16 = 16'hFFFF;
  localparam logic [15:0] EXP_C17 = 16'hFFFF;
`else
  localparam logic [15:0] EXP_C16 = 16'h0000;
  localparam logic [15:0] EXP_C17 = 16'h1111;
`endif

  initial begin
    rst = 1'b1; in = '0; busy = 1'b0; snap_ready = 1'b0;
    step(); step();
    check("rst_count", 32'(count), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_sdata", 32'(snap_data), 32'h0);
    check("rst_svalid", 32'(snap_valid), 32'h0);
    check("rst_sdrop", 32'(snap_drop), 32'h0);

    // Wrap / saturate: increment every channel for 17 cycles
    rst = 1'b0; in = 4'b1111;
    for (int i = 0; i < 15; i++) step();
    check("cnt15", 32'(count), 32'hFFFF);
    check("ovf15", 32'(ovf), 32'h0);
    step();
    check("cnt16", 32'(count), 32'(EXP_C16));
    check("ovf16", 32'(ovf), 32'hF);
    step();
    check("cnt17", 32'(count), 32'(EXP_C17));
    check("ovf17", 32'(ovf), 32'hF);

    // One-cycle busy pulse: one capture, then reload
    busy = 1'b1;
    step();
    check("pulse_sdata", 32'(snap_data), 32'(EXP_C17));
    check("pulse_svalid", 32'(snap_valid), 32'h1);
    check("pulse_cnt_hold", 32'(count), 32'(EXP_C17));
    busy = 1'b0; in = 4'b0101;
    step();
    check("pulse_reload", 32'(count), 32'h0101);
    check("pulse_ovf_clr", 32'(ovf), 32'h0);
    check("pulse_svalid2", 32'(snap_valid), 32'h1);
    snap_ready = 1'b1; in = 4'b0000;
    step();
    check("pulse_read", 32'(snap_valid), 32'h0);
    check("pulse_cnt_run", 32'(count), 32'h0101);
    snap_ready = 1'b0;

    // Build counts ch0..ch3 = 3,5,0,7
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in = {1'b1, 1'b0, (i < 5) ? 1'b1 : 1'b0, (i < 3) ? 1'b1 : 1'b0};
      step();
    end
    check("build_cnt", 32'(count), 32'h7053);

    // Three-cycle busy window; in is ignored while held
    busy = 1'b1; in = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      check("win_cnt_hold", 32'(count), 32'h7053);
      check("win_sdata", 32'(snap_data), 32'h7053);
      check("win_svalid", 32'(snap_valid), 32'h1);
    end
    busy = 1'b0; in = 4'b1101;
    step();
    check("win_reload", 32'(count), 32'h1101);
    check("win_ovf", 32'(ovf), 32'h0);

    // Second window with unread snapshot: overwrite and drop pulse
    in = 4'b0001;
    step();
    check("ow_cnt", 32'(count), 32'h1102);
    busy = 1'b1;
    step();
    check("ow_drop", 32'(snap_drop), 32'h1);
    check("ow_sdata", 32'(snap_data), 32'h1102);
    busy = 1'b0; in = 4'b0000;
    step();
    check("ow_drop_clr", 32'(snap_drop), 32'h0);
    check("ow_reload", 32'(count), 32'h0);
    snap_ready = 1'b1;
    step();
    check("ow_read", 32'(snap_valid), 32'h0);
    check("ow_sdata_keep", 32'(snap_data), 32'h1102);
    snap_ready = 1'b0;

    // Reset while in HOLD with a pending snapshot
    in = 4'b0011;
    step();
    busy = 1'b1;
    step();
    check("rh_pre_svalid", 32'(snap_valid), 32'h1);
    check("rh_pre_sdata", 32'(snap_data), 32'h0011);
    rst = 1'b1; in = 4'b1111;
    step();
    check("rh_count", 32'(count), 32'h0);
    check("rh_sdata", 32'(snap_data), 32'h0);
    check("rh_svalid", 32'(snap_valid), 32'h0);
    rst = 1'b0;
    step();
    check("rh_cap_svalid", 32'(snap_valid), 32'h1);
    check("rh_cap_sdata", 32'(snap_data), 32'h0);
    check("rh_cap_drop", 32'(snap_drop), 32'h0);
    check("rh_cap_cnt", 32'(count), 32'h0);
    step();
    check("rh_hold_cnt", 32'(count), 32'h0);
    busy = 1'b0; in = 4'b1000;
    step();
    check("rh_reload", 32'(count), 32'h1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_count_adder.md
# multi_count_adder

Parametrised, multi-channel successor to the single-bit pixel count adder in the image-sorting pre-pass. Each of `CH` channels accumulates a per-cycle increment into a `CW`-bit counter. All channels freeze while the downstream sorter is busy and restart from the current increment when it releases. The count reached at the start of every busy window is captured into a snapshot register with a valid/ready handshake, so the sorter can read per-class totals without stalling the counters.

## Interface
Parameters:
- `CH`, 4, number of channels
- `CW`, 15, counter width per channel
- `IW`, 1, increment width per channel (unsigned)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; **synchronous, active-high**
- `in`  in  CH*IW  per-channel increments; channel k occupies `[k*IW +: IW]`
- `busy`  in  1  sorter busy; counters hold while high
- `count`  out  CH*CW  live counters; channel k occupies `[k*CW +: CW]`
- `ovf`  out  CH  sticky per-channel overflow/saturation flag
- `snap_data`  out  CH*CW  captured counters
- `snap_valid`  out  1  snapshot available
- `snap_ready`  in  1  consumer accepts the snapshot
- `snap_drop`  out  1  one-cycle pulse: an unread snapshot was overwritten

## Operation
- Two-state FSM, shared by all channels: RUN and HOLD.
- RUN with `busy`=0: `count[k] <= count[k] + in[k]`, with `in` zero-extended to CW bits. Stay in RUN.
- RUN with `busy`=1:
  - `count` holds.
  - `snap_data <= count` (values before this edge).
  - `snap_valid <= 1`.
  - Go to HOLD.
- HOLD with `busy`=1: everything holds.
- HOLD with `busy`=0 (reload):
  - `count[k] <= in[k]` (zero-extended).
  - `ovf[k] <= 0`.
  - Go to RUN.
- Overflow, default build: the add wraps mod 2^CW. `ovf[k]` is set on carry-out and stays set until reload or reset.
- Snapshot handshake:
  - `snap_valid && snap_ready` clears `snap_valid`, unless a capture happens on the same edge. In that case the new data loads and `snap_valid` stays 1.
  - A capture while `snap_valid`=1 and `snap_ready`=0 overwrites `snap_data` and pulses `snap_drop`.
  - `snap_data` is stable while `snap_valid`=1 and no capture occurs.

## Timing
- All outputs are registered.
- Reset values:
  - `count` = 0, `ovf` = 0.
  - `snap_data` = 0, `snap_valid` = 0, `snap_drop` = 0.
  - FSM in RUN.
- `rst` overrides every other input on the same edge, including mid-HOLD and mid-handshake.
- Latency:
  - `in` sampled at edge n is visible on `count` after edge n.
  - A `busy` rise sampled at edge n gives `snap_valid`=1 after edge n.
- Every busy window, including a one-cycle pulse, produces exactly one capture and exactly one reload.
- `in` is ignored in HOLD except on the reload edge.

## Configuration
- `COUNT_SAT_EN` defined:
  - Each counter clamps at 2^CW−1 instead of wrapping.
  - `ovf[k]` is set when an add would exceed the maximum; the counter stays at 2^CW−1.
  - Reload still loads `in[k]`.
- `COUNT_SAT_EN` undefined: modulo-2^CW wrap as described under Operation.

## Structure
- Package `count_pkg` holds:
  - the FSM state enum (RUN, HOLD);
  - default constants `COUNT_CH`, `COUNT_CW`, `COUNT_IW`.
- Sub-module `count_lane`:
  - one channel's CW-bit accumulator, reload mux, and wrap/saturate logic plus `ovf`;
  - instantiated CH times by generate;
  - driven by FSM decode from the top: `hold`, `reload`.
- The top level owns the FSM, the snapshot register and the handshake.

## Test plan
- Reset and wrap:
  - stimulus: `rst`=1 for 2 cycles, then CH=4, CW=4, `in`=1 on all channels for 17 cycles, `busy`=0;
  - response: all counts go 0→15→0→1; `ovf`=4'b1111 (wrap build).
- Same stimulus with `COUNT_SAT_EN`: counts stick at 15 and `ovf`=4'b1111.
- Busy window:
  - stimulus: counts {3,5,0,7}, then `busy`=1 for 3 cycles, then `busy`=0 with `in`={1,0,1,1};
  - response: `snap_data`={3,5,0,7}, `snap_valid`=1, counts hold for 3 cycles, then load {1,0,1,1} and `ovf` clears.
- One-cycle `busy` pulse: exactly one snapshot, then the reload to `in` on the next edge.
- Overwrite: two busy windows with `snap_ready`=0 gives one `snap_drop` pulse and `snap_data` holding the second capture; then `snap_ready`=1 clears `snap_valid` after one edge.
- Reset in HOLD:
  - stimulus: `rst`=1 while `busy`=1 and `snap_valid`=1;
  - response: all outputs 0 and FSM in RUN; with `busy` still high on the next edge, the FSM captures (`snap_data`=0) and enters HOLD.
